// File: rtl/vga_tile_renderer_if.sv
// -----------------------------------------------------------------------------
// vga_tile_renderer_if
//   Bundles every non-clock signal of the tile renderer:
//     - raster input from the VGA timing driver (x, y, video_on, hsync_i, vsync_i)
//     - tile-map write port from game logic (wr_en, wr_col, wr_row, wr_data)
//     - cursor controls (cursor_en, cursor_col, cursor_row)
//     - video output to the DAC (r, g, b, hsync_o, vsync_o, blank_n) and frame_tick
//   master : timing driver / game logic side (drives raster, writes, cursor)
//   slave  : the renderer (drives the colour and sync outputs)
// -----------------------------------------------------------------------------
interface vga_tile_renderer_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync_i;
  logic       vsync_i;

  logic       wr_en;
  logic [2:0] wr_col;
  logic [2:0] wr_row;
  logic [1:0] wr_data;

  logic       cursor_en;
  logic [2:0] cursor_col;
  logic [2:0] cursor_row;

  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       hsync_o;
  logic       vsync_o;
  logic       blank_n;
  logic       frame_tick;

  modport master (
    output x, y, video_on, hsync_i, vsync_i,
    output wr_en, wr_col, wr_row, wr_data,
    output cursor_en, cursor_col, cursor_row,
    input  r, g, b, hsync_o, vsync_o, blank_n, frame_tick
  );

  modport slave (
    input  x, y, video_on, hsync_i, vsync_i,
    input  wr_en, wr_col, wr_row, wr_data,
    input  cursor_en, cursor_col, cursor_row,
    output r, g, b, hsync_o, vsync_o, blank_n, frame_tick
  );
endinterface

// File: rtl/vga_tile_renderer.sv
// -----------------------------------------------------------------------------
// vga_tile_renderer
//   Pixel-colour stage behind the VGA timing driver. Draws a GRID_COLS x
//   GRID_ROWS board of square tiles from an internal 2-bit tile map, with grid
//   lines on each tile's low edge and a blinking cursor frame.
//   Two-stage pipeline: stage 1 maps the raster position onto board/tile
//   coordinates, stage 2 looks up the tile and picks the colour. RGB and the
//   delayed sync/blank signals all leave exactly two clocks after their inputs.
// Ports
//   clk   : pixel clock
//   reset : synchronous, active-high; clears tile map, pipeline and blink state
//   bus   : vga_tile_renderer_if.slave (raster in, map writes, cursor, video out)
// -----------------------------------------------------------------------------
module vga_tile_renderer #(
  parameter int TILE_LOG2    = 6,
  parameter int GRID_COLS    = 8,
  parameter int GRID_ROWS    = 6,
  parameter int ORIGIN_X     = 64,
  parameter int ORIGIN_Y     = 48,
  parameter int BLINK_FRAMES = 30,
  parameter int LINE_W       = 2,
  parameter int CURSOR_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  vga_tile_renderer_if.slave  bus
);

  localparam int TILE = 2 ** TILE_LOG2;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0] BOARD_W = 11'(GRID_COLS << TILE_LOG2);
  localparam logic [10:0] BOARD_H = 11'(GRID_ROWS << TILE_LOG2);
  localparam logic [3:0]  COLS_L  = 4'(GRID_COLS);
  localparam logic [3:0]  ROWS_L  = 4'(GRID_ROWS);

  localparam logic [TILE_LOG2-1:0] LINE_LIM   = TILE_LOG2'(LINE_W);
  localparam logic [TILE_LOG2-1:0] CUR_LO_LIM = TILE_LOG2'(CURSOR_W);
  localparam logic [TILE_LOG2-1:0] CUR_HI_LIM = TILE_LOG2'(TILE - CURSOR_W);
  localparam logic [CNT_W-1:0]     BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  localparam logic [23:0] RGB_BLACK  = 24'h000000;
  localparam logic [23:0] RGB_CURSOR = 24'hFFFF00;
  localparam logic [23:0] RGB_LINE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_EMPTY  = 24'h202020;
  localparam logic [23:0] RGB_A      = 24'hE02020;
  localparam logic [23:0] RGB_B      = 24'h2040E0;
  localparam logic [23:0] RGB_HILITE = 24'h20C040;

  // ---------------------------------------------------------------------------
  // Stage 1: board-relative coordinates. Both are 11-bit two's complement, so
  // bit 10 set means the pixel is left of / above the board origin.
  // ---------------------------------------------------------------------------
  logic [10:0] w_rx;
  logic [10:0] w_ry;
  logic        w_in_board;

  assign w_rx = {1'b0, bus.x} - 11'(ORIGIN_X);
  assign w_ry = {1'b0, bus.y} - 11'(ORIGIN_Y);
  assign w_in_board = !w_rx[10] && !w_ry[10] && (w_rx < BOARD_W) && (w_ry < BOARD_H);

  logic                 r_von_d1;
  logic                 r_hs_d1;
  logic                 r_vs_d1;
  logic                 r_in_board;
  logic [2:0]           r_col;
  logic [2:0]           r_row;
  logic [TILE_LOG2-1:0] r_ox;
  logic [TILE_LOG2-1:0] r_oy;

  // NOTE: clocked state uses non-blocking assignments so every register in the
  // pipeline samples the pre-edge values and stages advance together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_von_d1   <= 1'b0;
      r_hs_d1    <= 1'b0;
      r_vs_d1    <= 1'b0;
      r_in_board <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_ox       <= '0;
      r_oy       <= '0;
    end else begin
      r_von_d1   <= bus.video_on;
      r_hs_d1    <= bus.hsync_i;
      r_vs_d1    <= bus.vsync_i;
      r_in_board <= w_in_board;
      r_col      <= w_rx[TILE_LOG2 +: 3];
      r_row      <= w_ry[TILE_LOG2 +: 3];
      r_ox       <= w_rx[TILE_LOG2-1:0];
      r_oy       <= w_ry[TILE_LOG2-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Tile map. Read asynchronously in stage 2, so a write on the same edge that
  // registers a stage-2 pixel is seen only by the following pixel.
  // ---------------------------------------------------------------------------
  logic [1:0] r_map [8][8];
  logic       w_wr_ok;

  assign w_wr_ok = bus.wr_en && ({1'b0, bus.wr_col} < COLS_L) && ({1'b0, bus.wr_row} < ROWS_L);

  // NOTE: the map is flop-based and must read as empty straight after reset,
  // so every entry is cleared explicitly rather than left to power-up state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          r_map[i][j] <= 2'd0;
        end
      end
    end else if (w_wr_ok) begin
      r_map[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame tick and cursor blink. The tick fires on the first pixel of vblank
  // and is not delayed with the video pipeline.
  // ---------------------------------------------------------------------------
  logic             r_frame_tick;
  logic [CNT_W-1:0] r_blink_cnt;
  logic             r_blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_tick  <= 1'b0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_frame_tick <= (bus.x == 10'd0) && (bus.y == 10'd480);
      if (r_frame_tick) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour selection by priority.
  // ---------------------------------------------------------------------------
  logic [1:0]  w_tile;
  logic        w_cursor_tile;
  logic        w_cursor_edge;
  logic        w_line;
  logic [23:0] w_rgb;

  assign w_tile        = r_map[r_row][r_col];
  // Out-of-range cursor coordinates can never equal a board tile, but the
  // explicit bound keeps that property independent of the grid parameters.
  assign w_cursor_tile = bus.cursor_en && r_blink_phase &&
                         ({1'b0, bus.cursor_col} < COLS_L) && ({1'b0, bus.cursor_row} < ROWS_L) &&
                         (r_col == bus.cursor_col) && (r_row == bus.cursor_row);
  assign w_cursor_edge = (r_ox < CUR_LO_LIM) || (r_ox >= CUR_HI_LIM) ||
                         (r_oy < CUR_LO_LIM) || (r_oy >= CUR_HI_LIM);
  assign w_line        = (r_ox < LINE_LIM) || (r_oy < LINE_LIM);

  // NOTE: w_rgb gets a default before the priority chain so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rgb = RGB_BLACK;
    if (!r_von_d1 || !r_in_board) begin
      w_rgb = RGB_BLACK;
    end else if (w_cursor_tile && w_cursor_edge) begin
      w_rgb = RGB_CURSOR;
    end else if (w_line) begin
      w_rgb = RGB_LINE;
    end else begin
      case (w_tile)
        2'd0:    w_rgb = RGB_EMPTY;
        2'd1:    w_rgb = RGB_A;
        2'd2:    w_rgb = RGB_B;
        default: w_rgb = RGB_HILITE;
      endcase
    end
  end

  logic [23:0] r_rgb;
  logic        r_hs_d2;
  logic        r_vs_d2;
  logic        r_von_d2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb    <= '0;
      r_hs_d2  <= 1'b0;
      r_vs_d2  <= 1'b0;
      r_von_d2 <= 1'b0;
    end else begin
      r_rgb    <= w_rgb;
      r_hs_d2  <= r_hs_d1;
      r_vs_d2  <= r_vs_d1;
      r_von_d2 <= r_von_d1;
    end
  end

  assign bus.r          = r_rgb[23:16];
  assign bus.g          = r_rgb[15:8];
  assign bus.b          = r_rgb[7:0];
  assign bus.hsync_o    = r_hs_d2;
  assign bus.vsync_o    = r_vs_d2;
  assign bus.blank_n    = r_von_d2;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// -----------------------------------------------------------------------------
// tb_vga_tile_renderer
//   Directed bench for vga_tile_renderer with default parameters. Each driven
//   pixel pushes its expected colour and sync/blank onto a scoreboard queue,
//   tagged with the cycle it must appear; a negedge monitor pops and compares.
//   Frame ticks are produced by briefly presenting x=0,y=480 instead of
//   running full 800x525 frames.
// -----------------------------------------------------------------------------
module tb_vga_tile_renderer;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_ticks = 0;

  vga_tile_renderer_if vif ();

  vga_tile_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (vif.frame_tick === 1'b1) n_ticks <= n_ticks + 1;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic [2:0]  sync;   // {hsync_o, vsync_o, blank_n}
    string       tag;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: compares each expectation on the cycle it falls due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, " rgb"}, {8'h00, vif.r, vif.g, vif.b}, {8'h00, e.rgb});
      check({e.tag, " sync"}, {29'd0, vif.hsync_o, vif.vsync_o, vif.blank_n}, {29'd0, e.sync});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    vif.wr_en = 1'b0;
  endtask

  task automatic idle();
    vif.x = 10'd700;
    vif.y = 10'd10;
    vif.video_on = 1'b0;
    vif.hsync_i = 1'b1;
    vif.vsync_i = 1'b1;
  endtask

  task automatic px(input int xv, input int yv, input logic von, input logic hs,
                    input logic vs, input logic [23:0] rgb, input string tag);
    exp_t e;
    vif.x = 10'(xv);
    vif.y = 10'(yv);
    vif.video_on = von;
    vif.hsync_i = hs;
    vif.vsync_i = vs;
    e.due = cyc + 2;
    e.rgb = rgb;
    e.sync = {hs, vs, von};
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic set_wr(input int col, input int row, input int data);
    vif.wr_en = 1'b1;
    vif.wr_col = 3'(col);
    vif.wr_row = 3'(row);
    vif.wr_data = 2'(data);
  endtask

  // Holds reset for three edges with live active-video inputs and checks
  // that everything reads zero after each edge.
  task automatic do_reset(input string tag);
    vif.wr_en = 1'b0;
    vif.x = 10'd100;
    vif.y = 10'd100;
    vif.video_on = 1'b1;
    vif.hsync_i = 1'b1;
    vif.vsync_i = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check({tag, " rgb"}, {8'h00, vif.r, vif.g, vif.b}, 32'h0);
      check({tag, " sync/blank/tick"},
            {28'd0, vif.hsync_o, vif.vsync_o, vif.blank_n, vif.frame_tick}, 32'h0);
    end
    reset = 1'b0;
    idle();
  endtask

  task automatic gen_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      vif.x = 10'd0;
      vif.y = 10'd480;
      vif.video_on = 1'b0;
      step();
      idle();
      step();
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic scan_empty(input string tag);
    for (int row = 0; row < 6; row++) begin
      for (int col = 0; col < 8; col++) begin
        step();
        px(64 + col * 64 + 20, 48 + row * 64 + 20, 1'b1, 1'b1, 1'b1, 24'h202020,
           $sformatf("%s_c%0d_r%0d", tag, col, row));
      end
    end
  endtask

  initial begin
    int base;
    reset = 1'b0;
    vif.wr_en = 1'b0;
    vif.wr_col = 3'd0;
    vif.wr_row = 3'd0;
    vif.wr_data = 2'd0;
    vif.cursor_en = 1'b0;
    vif.cursor_col = 3'd0;
    vif.cursor_row = 3'd0;
    idle();

    do_reset("init_reset");

    // Basic pixels, board edges and sync delay.
    step(); px(100, 100, 1, 1, 1, 24'h202020, "t00_interior");
    step(); px(64,  100, 1, 1, 1, 24'hFFFFFF, "left_line");
    step(); px(63,  100, 1, 1, 1, 24'h000000, "left_out");
    step(); px(575, 100, 1, 1, 1, 24'h202020, "right_edge_in");
    step(); px(576, 100, 1, 1, 1, 24'h000000, "right_out");
    step(); px(100, 431, 1, 1, 1, 24'h202020, "bottom_edge_in");
    step(); px(100, 432, 1, 1, 1, 24'h000000, "bottom_out");
    step(); px(100, 47,  1, 1, 1, 24'h000000, "top_out");
    step(); px(100, 48,  1, 1, 1, 24'hFFFFFF, "top_line");
    step(); px(100, 100, 1, 0, 1, 24'h202020, "hsync_low");
    step(); px(100, 100, 1, 1, 0, 24'h202020, "vsync_low");

    // Map writes and every tile code.
    step(); set_wr(2, 1, 2);
    step(); set_wr(1, 0, 1); px(202, 122, 1, 1, 1, 24'h2040E0, "tile21_B");
    step(); set_wr(4, 3, 3); px(192, 122, 1, 1, 1, 24'hFFFFFF, "tile21_vline");
    step(); px(202, 112, 1, 1, 1, 24'hFFFFFF, "tile21_hline");
    step(); px(10,  122, 1, 1, 1, 24'h000000, "off_board");
    step(); px(148, 68,  1, 1, 1, 24'hE02020, "tile10_A");
    step(); px(340, 260, 1, 1, 1, 24'h20C040, "tile43_hilite");

    // Out-of-range write, blanking.
    step(); set_wr(7, 7, 1); idle();
    step(); px(700, 100, 0, 1, 1, 24'h000000, "blank_x700");
    step(); px(202, 122, 0, 1, 1, 24'h000000, "blank_on_board");
    step(); idle();
    drain("drain_before_mid_reset");

    // Mid-line reset clears map and pipeline.
    vif.x = 10'd202;
    vif.y = 10'd122;
    vif.video_on = 1'b1;
    step();
    step();
    do_reset("mid_reset");
    step();
    step();
    scan_empty("after_reset");

    // Writes outside the board must not touch any visible tile.
    step(); set_wr(7, 7, 1); idle();
    step(); set_wr(0, 6, 1);
    step(); set_wr(7, 6, 2);
    scan_empty("after_oob_write");

    // Write landing on the same edge as a stage-2 read of that tile.
    step(); px(100, 100, 1, 1, 1, 24'h202020, "same_cycle_old");
    step(); px(101, 100, 1, 1, 1, 24'hE02020, "same_cycle_new"); set_wr(0, 0, 1);
    step(); idle();
    drain("drain_before_cursor");

    // Frame tick shape.
    vif.cursor_en = 1'b1;
    vif.cursor_col = 3'd3;
    vif.cursor_row = 3'd2;
    base = n_ticks;
    step(); vif.x = 10'd0; vif.y = 10'd480; vif.video_on = 1'b0;
    @(negedge clk);
    check("frame_tick_not_early", {31'd0, vif.frame_tick}, 32'd0);
    step();
    check("frame_tick_pulse", {31'd0, vif.frame_tick}, 32'd1);
    idle();
    step();
    check("frame_tick_width", {31'd0, vif.frame_tick}, 32'd0);

    // Cursor blink.
    gen_ticks(28);
    step(); px(257, 196, 1, 1, 1, 24'hFFFFFF, "cursor_after_29_ticks");
    step(); idle();
    gen_ticks(1);
    check("tick_count_30", 32'(n_ticks - base), 32'd30);
    step(); px(257, 196, 1, 1, 1, 24'hFFFF00, "cursor_over_line");
    step(); px(286, 238, 1, 1, 1, 24'hFFFF00, "cursor_bottom_frame");
    step(); px(276, 196, 1, 1, 1, 24'h202020, "cursor_interior");
    step(); px(257, 196, 1, 1, 1, 24'hFFFFFF, "cursor_row_oob");
    step(); vif.cursor_row = 3'd6; idle();
    step(); vif.cursor_row = 3'd2;
    step(); px(257, 196, 1, 1, 1, 24'hFFFFFF, "cursor_disabled");
    step(); vif.cursor_en = 1'b0; idle();
    step(); vif.cursor_en = 1'b1;
    step(); px(320, 196, 1, 1, 1, 24'hFFFFFF, "cursor_other_tile_line");
    step(); idle();
    gen_ticks(30);
    check("tick_count_60", 32'(n_ticks - base), 32'd60);
    step(); px(257, 196, 1, 1, 1, 24'hFFFFFF, "cursor_blink_off");
    step(); idle();

    drain("final_drain");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
